// File: rtl/dcache_wb.sv
// Direct-mapped write-back, write-allocate data cache between a byte-wide CPU port
// and a word-wide multi-cycle memory; a dirty victim is written back before the refill.
module dcache_wb #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        CPU_READ,
    input  logic        CPU_WRITE,
    input  logic [7:0]  CPU_ADDRESS,
    input  logic [7:0]  CPU_WRITEDATA,
    output logic [7:0]  CPU_READDATA,
    output logic        CPU_BUSYWAIT,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [5:0]  DM_ADDRESS,
    output logic [31:0] DM_WRITEDATA,
    input  logic [31:0] DM_READDATA,
    input  logic        DM_BUSYWAIT
);

    localparam int IDX_W = $clog2(NUM_BLOCKS);
    localparam int OFF_W = $clog2(BLOCK_BYTES);
    localparam int TAG_W = 8 - IDX_W - OFF_W;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MEM_READ  = 2'd1,
        S_MEM_WRITE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [NUM_BLOCKS-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]   tag_q  [NUM_BLOCKS];
    logic [31:0]        data_q [NUM_BLOCKS];

    logic               dm_read_q, dm_read_d;
    logic               dm_write_q, dm_write_d;
    logic [5:0]         dm_addr_q, dm_addr_d;
    logic [31:0]        dm_wdata_q, dm_wdata_d;

    logic [TAG_W-1:0]   tag_s;
    logic [IDX_W-1:0]   idx_s;
    logic [OFF_W-1:0]   off_s;
    logic               req_s, hit_s, fill_s, wr_hit_s;

    assign tag_s = CPU_ADDRESS[7:8-TAG_W];
    assign idx_s = CPU_ADDRESS[OFF_W+IDX_W-1:OFF_W];
    assign off_s = CPU_ADDRESS[OFF_W-1:0];
    assign req_s = CPU_READ | CPU_WRITE;
    assign hit_s = valid_q[idx_s] && (tag_q[idx_s] == tag_s);

    assign CPU_BUSYWAIT = req_s && !((state_q == S_IDLE) && hit_s);
    assign CPU_READDATA = data_q[idx_s][{off_s, 3'b000} +: 8];

    assign DM_READ      = dm_read_q;
    assign DM_WRITE     = dm_write_q;
    assign DM_ADDRESS   = dm_addr_q;
    assign DM_WRITEDATA = dm_wdata_q;

    // Next-state logic; memory request outputs are derived from the next state so they register with it.
    always_comb begin
        state_d    = state_q;
        fill_s     = 1'b0;
        wr_hit_s   = 1'b0;
        dm_read_d  = 1'b0;
        dm_write_d = 1'b0;
        dm_addr_d  = 6'd0;
        dm_wdata_d = 32'd0;
        case (state_q)
            S_IDLE: begin
                if (req_s && !hit_s) begin
                    if (valid_q[idx_s] && dirty_q[idx_s]) begin
                        state_d = S_MEM_WRITE;
                    end else begin
                        state_d = S_MEM_READ;
                    end
                end else if (CPU_WRITE && hit_s) begin
                    wr_hit_s = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MEM_WRITE: begin
                if (!DM_BUSYWAIT) begin
                    state_d = S_MEM_READ;
                end else begin
                    state_d = S_MEM_WRITE;
                end
            end
            S_MEM_READ: begin
                if (!DM_BUSYWAIT) begin
                    state_d = S_IDLE;
                    fill_s  = 1'b1;
                end else begin
                    state_d = S_MEM_READ;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_MEM_WRITE: begin
                dm_write_d = 1'b1;
                dm_addr_d  = {tag_q[idx_s], idx_s};
                dm_wdata_d = data_q[idx_s];
            end
            S_MEM_READ: begin
                dm_read_d = 1'b1;
                dm_addr_d = {tag_s, idx_s};
            end
            default: begin
                dm_read_d  = 1'b0;
                dm_write_d = 1'b0;
            end
        endcase
    end

    // State, request outputs and per-line valid/dirty flags; reset aborts any miss.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q    <= S_IDLE;
            dm_read_q  <= 1'b0;
            dm_write_q <= 1'b0;
            dm_addr_q  <= 6'd0;
            dm_wdata_q <= 32'd0;
            valid_q    <= '0;
            dirty_q    <= '0;
        end else begin
            state_q    <= state_d;
            dm_read_q  <= dm_read_d;
            dm_write_q <= dm_write_d;
            dm_addr_q  <= dm_addr_d;
            dm_wdata_q <= dm_wdata_d;
            if (fill_s) begin
                valid_q[idx_s] <= 1'b1;
                dirty_q[idx_s] <= 1'b0;
            end else if (wr_hit_s) begin
                dirty_q[idx_s] <= 1'b1;
            end
        end
    end

    // Line tag/data storage: refill from memory or byte store on a write hit.
    always_ff @(posedge CLK) begin
        if (RESET && fill_s) begin
            data_q[idx_s] <= DM_READDATA;
            tag_q[idx_s]  <= tag_s;
        end else if (RESET && wr_hit_s) begin
            data_q[idx_s][{off_s, 3'b000} +: 8] <= CPU_WRITEDATA;
        end
    end

endmodule

// File: tb/tb_dcache_wb.sv
// Table-driven bench for dcache_wb with a behavioural word memory and
// scoreboards for expected memory transactions and load data.
module tb_dcache_wb;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        CPU_READ, CPU_WRITE;
    logic [7:0]  CPU_ADDRESS, CPU_WRITEDATA, CPU_READDATA;
    logic        CPU_BUSYWAIT;
    logic        DM_READ, DM_WRITE;
    logic [5:0]  DM_ADDRESS;
    logic [31:0] DM_WRITEDATA, DM_READDATA;
    logic        DM_BUSYWAIT;

    int checks = 0;
    int errors = 0;

    dcache_wb dut (
        .CLK(CLK), .RESET(RESET),
        .CPU_READ(CPU_READ), .CPU_WRITE(CPU_WRITE),
        .CPU_ADDRESS(CPU_ADDRESS), .CPU_WRITEDATA(CPU_WRITEDATA),
        .CPU_READDATA(CPU_READDATA), .CPU_BUSYWAIT(CPU_BUSYWAIT),
        .DM_READ(DM_READ), .DM_WRITE(DM_WRITE),
        .DM_ADDRESS(DM_ADDRESS), .DM_WRITEDATA(DM_WRITEDATA),
        .DM_READDATA(DM_READDATA), .DM_BUSYWAIT(DM_BUSYWAIT)
    );

    always #5 CLK = ~CLK;

    // Memory model: fixed initial image plus an overlay of written-back words.
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic [31:0] wb_mem [64];
    logic [63:0] wb_vld = 64'd0;

    function automatic logic [31:0] init_word(input logic [5:0] a);
        case (a)
            6'h01:   return 32'hDDCCBBAA;
            6'h03:   return 32'h11223344;
            6'h08:   return 32'h44332211;
            6'h09:   return 32'h87654321;
            default: return 32'h00000000;
        endcase
    endfunction

    assign DM_READDATA = wb_vld[DM_ADDRESS] ? wb_mem[DM_ADDRESS] : init_word(DM_ADDRESS);
    assign DM_BUSYWAIT = (DM_READ || DM_WRITE) && (wait_cnt < mem_lat);

    always @(posedge CLK) begin
        if ((DM_READ || DM_WRITE) && DM_BUSYWAIT) wait_cnt <= wait_cnt + 1;
        else wait_cnt <= 0;
        if (RESET && DM_WRITE && !DM_BUSYWAIT) begin
            wb_mem[DM_ADDRESS] <= DM_WRITEDATA;
            wb_vld[DM_ADDRESS] <= 1'b1;
        end
    end

    typedef struct packed {
        logic        is_wr;
        logic [5:0]  addr;
        logic [31:0] data;
    } dm_t;

    dm_t        dm_exp_q [$];
    logic [7:0] rd_exp_q [$];

    // Memory transaction monitor: a request completes at the next edge when busywait is low now.
    always @(negedge CLK) begin
        if (RESET && (DM_READ || DM_WRITE) && !DM_BUSYWAIT) begin
            checks++;
            if (dm_exp_q.size() == 0) begin
                errors++;
                $display("FAIL dm_unexpected: got rd=%0b wr=%0b addr=%h data=%h, expected none",
                         DM_READ, DM_WRITE, DM_ADDRESS, DM_WRITEDATA);
            end else begin
                dm_t e;
                e = dm_exp_q.pop_front();
                if ((DM_READ && DM_WRITE) || (DM_WRITE != e.is_wr) || (DM_READ == e.is_wr) ||
                    (DM_ADDRESS != e.addr) || (e.is_wr && DM_WRITEDATA != e.data)) begin
                    errors++;
                    $display("FAIL dm_txn: got rd=%0b wr=%0b addr=%h data=%h, expected wr=%0b addr=%h data=%h",
                             DM_READ, DM_WRITE, DM_ADDRESS, DM_WRITEDATA, e.is_wr, e.addr, e.data);
                end
            end
        end
    end

    typedef struct {
        logic        rd;
        logic        wr;
        logic [7:0]  addr;
        logic [7:0]  wdata;
        logic        hit;
        logic [7:0]  rdata;
        logic        wb;
        logic [5:0]  wb_addr;
        logic [31:0] wb_data;
        logic        fill;
        logic [5:0]  fill_addr;
    } vec_t;

    function automatic vec_t mk(input logic rd, input logic wr, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic hit, input logic [7:0] rdata,
                                input logic wb, input logic [5:0] wb_addr, input logic [31:0] wb_data,
                                input logic fill, input logic [5:0] fill_addr);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.hit = hit; v.rdata = rdata;
        v.wb = wb; v.wb_addr = wb_addr; v.wb_data = wb_data; v.fill = fill; v.fill_addr = fill_addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    // Drives one access (called just after a rising edge) and waits for it to complete.
    task automatic do_access(input vec_t v);
        int n;
        dm_t e;
        if (v.wb) begin
            e.is_wr = 1'b1; e.addr = v.wb_addr; e.data = v.wb_data;
            dm_exp_q.push_back(e);
        end
        if (v.fill) begin
            e.is_wr = 1'b0; e.addr = v.fill_addr; e.data = 32'd0;
            dm_exp_q.push_back(e);
        end
        if (v.rd && !v.wr) rd_exp_q.push_back(v.rdata);
        CPU_READ = v.rd; CPU_WRITE = v.wr; CPU_ADDRESS = v.addr; CPU_WRITEDATA = v.wdata;
        @(negedge CLK);
        check($sformatf("first_busy@%h", v.addr), {31'd0, CPU_BUSYWAIT}, {31'd0, !v.hit});
        n = 0;
        while (CPU_BUSYWAIT && n < 80) begin
            @(negedge CLK);
            n++;
        end
        if (CPU_BUSYWAIT) check($sformatf("busy_timeout@%h", v.addr), 32'd1, 32'd0);
        if (v.rd && !v.wr && rd_exp_q.size() > 0)
            check($sformatf("rdata@%h", v.addr), {24'd0, CPU_READDATA}, {24'd0, rd_exp_q.pop_front()});
        @(posedge CLK);
        #1;
        CPU_READ = 1'b0; CPU_WRITE = 1'b0;
        check($sformatf("dm_pending@%h", v.addr), dm_exp_q.size(), 32'd0);
    endtask

    vec_t tbl [15];

    initial begin
        int n;
        int busy_cnt;
        logic held;

        tbl[0]  = mk(1'b0, 1'b1, 8'h00, 8'h5A, 1'b0, 8'h00, 1'b0, 6'h00, 32'h0,        1'b1, 6'h00);
        tbl[1]  = mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b1, 8'h5A, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[2]  = mk(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 8'h11, 1'b1, 6'h00, 32'h0000005A, 1'b1, 6'h08);
        tbl[3]  = mk(1'b1, 1'b0, 8'h07, 8'h00, 1'b0, 8'hDD, 1'b0, 6'h00, 32'h0,        1'b1, 6'h01);
        tbl[4]  = mk(1'b1, 1'b0, 8'h23, 8'h00, 1'b1, 8'h44, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[5]  = mk(1'b0, 1'b1, 8'h05, 8'h77, 1'b1, 8'h00, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[6]  = mk(1'b1, 1'b0, 8'h05, 8'h00, 1'b1, 8'h77, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[7]  = mk(1'b1, 1'b0, 8'h04, 8'h00, 1'b1, 8'hAA, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[8]  = mk(1'b1, 1'b0, 8'h25, 8'h00, 1'b0, 8'h43, 1'b1, 6'h01, 32'hDDCC77AA, 1'b1, 6'h09);
        tbl[9]  = mk(1'b1, 1'b0, 8'h05, 8'h00, 1'b0, 8'h77, 1'b0, 6'h00, 32'h0,        1'b1, 6'h01);
        tbl[10] = mk(1'b1, 1'b1, 8'hFF, 8'h99, 1'b0, 8'h00, 1'b0, 6'h00, 32'h0,        1'b1, 6'h3F);
        tbl[11] = mk(1'b1, 1'b0, 8'hFF, 8'h00, 1'b1, 8'h99, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[12] = mk(1'b1, 1'b0, 8'hFC, 8'h00, 1'b1, 8'h00, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);
        tbl[13] = mk(1'b1, 1'b0, 8'h1F, 8'h00, 1'b0, 8'h00, 1'b1, 6'h3F, 32'h99000000, 1'b1, 6'h07);
        tbl[14] = mk(1'b0, 1'b1, 8'h21, 8'hAB, 1'b1, 8'h00, 1'b0, 6'h00, 32'h0,        1'b0, 6'h00);

        RESET = 1'b0; CPU_READ = 1'b0; CPU_WRITE = 1'b0; CPU_ADDRESS = 8'h00; CPU_WRITEDATA = 8'h00;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_dm_read",  {31'd0, DM_READ},  32'd0);
        check("rst_dm_write", {31'd0, DM_WRITE}, 32'd0);
        check("rst_dm_addr",  {26'd0, DM_ADDRESS}, 32'd0);
        check("rst_dm_wdata", DM_WRITEDATA, 32'd0);
        check("rst_busy",     {31'd0, CPU_BUSYWAIT}, 32'd0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        for (int i = 0; i < 15; i++) do_access(tbl[i]);

        // Slow memory: five busy cycles during a clean refill of line 3.
        mem_lat = 5;
        begin
            dm_t e;
            e.is_wr = 1'b0; e.addr = 6'h03; e.data = 32'd0;
            dm_exp_q.push_back(e);
        end
        rd_exp_q.push_back(8'h44);
        CPU_READ = 1'b1; CPU_ADDRESS = 8'h0C;
        @(negedge CLK);
        check("slow_first_busy", {31'd0, CPU_BUSYWAIT}, 32'd1);
        @(negedge CLK);
        busy_cnt = 0;
        held = 1'b1;
        while (DM_BUSYWAIT && busy_cnt < 40) begin
            if (!(CPU_BUSYWAIT && DM_READ)) held = 1'b0;
            busy_cnt++;
            @(negedge CLK);
        end
        check("slow_busy_cycles", busy_cnt, 32'd5);
        check("slow_busy_held", {31'd0, held}, 32'd1);
        check("slow_busy_before_fill", {31'd0, CPU_BUSYWAIT}, 32'd1);
        n = 0;
        while (CPU_BUSYWAIT && n < 40) begin
            @(negedge CLK);
            n++;
        end
        check("slow_busy_fall", {31'd0, CPU_BUSYWAIT}, 32'd0);
        if (rd_exp_q.size() > 0) check("slow_rdata", {24'd0, CPU_READDATA}, {24'd0, rd_exp_q.pop_front()});
        @(posedge CLK);
        #1;
        CPU_READ = 1'b0;
        check("slow_dm_pending", dm_exp_q.size(), 32'd0);

        // Reset in the middle of a refill drops the request and invalidates every line.
        mem_lat = 20;
        CPU_READ = 1'b1; CPU_ADDRESS = 8'h10;
        n = 0;
        @(negedge CLK);
        while (!DM_READ && n < 10) begin
            @(negedge CLK);
            n++;
        end
        check("abort_dm_read_up", {31'd0, DM_READ}, 32'd1);
        check("abort_dm_addr", {26'd0, DM_ADDRESS}, 32'h04);
        RESET = 1'b0; CPU_READ = 1'b0;
        @(negedge CLK);
        check("abort_dm_read_down", {31'd0, DM_READ}, 32'd0);
        check("abort_dm_addr_zero", {26'd0, DM_ADDRESS}, 32'd0);
        check("abort_busy", {31'd0, CPU_BUSYWAIT}, 32'd0);
        RESET = 1'b1;
        mem_lat = 0;
        @(posedge CLK);
        #1;
        do_access(mk(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 8'h5A, 1'b0, 6'h00, 32'h0, 1'b1, 6'h00));

        repeat (2) @(posedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
